// File: rtl/isa_pkg.sv
// ISA constants shared by the IF/ID stage and the control unit.
package isa_pkg;

    typedef logic [5:0] opcode_t;

    // Opcodes, instr[31:26]
    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_ADDIU = 6'b001001;
    localparam opcode_t OP_SLTI  = 6'b001010;
    localparam opcode_t OP_SLTIU = 6'b001011;
    localparam opcode_t OP_ANDI  = 6'b001100;
    localparam opcode_t OP_ORI   = 6'b001101;
    localparam opcode_t OP_XORI  = 6'b001110;
    localparam opcode_t OP_LUI   = 6'b001111;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    // Instruction field bit positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID stage.
// slave: the stage itself; master: the surrounding fetch/decode logic.
interface if_id_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        se;
    logic        is_itype;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr,
        output rs, rt, rd, imm16, se, is_itype
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr,
        input  rs, rt, rd, imm16, se, is_itype
    );
endinterface

// File: rtl/id_imm_decode.sv
// Combinational register-field and immediate decode of an instruction word.
module id_imm_decode
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        se,
    output logic        is_itype
);

    opcode_t op;

    assign op    = instr[OP_MSB:OP_LSB];
    assign rs    = instr[RS_MSB:RS_LSB];
    assign rt    = instr[RT_MSB:RT_LSB];
    assign rd    = instr[RD_MSB:RD_LSB];
    assign imm16 = instr[IMM_MSB:IMM_LSB];

    // Classify opcode: arithmetic/compare/branch/memory immediates sign-extend,
    // logical immediates and lui zero-extend, everything else is not I-type.
    always_comb begin
        se       = 1'b0;
        is_itype = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE, OP_LW, OP_SW: begin
                se       = 1'b1;
                is_itype = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                is_itype = 1'b1;
            end
            default: begin
                se       = 1'b0;
                is_itype = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: single-entry valid/ready buffer with flush,
// presenting decoded fields of the held instruction.
module if_id_stage (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        ready;
    logic        accept;

    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [15:0] dec_imm16;
    logic        dec_se;
    logic        dec_is_itype;

    assign ready  = !valid_q || bus.out_ready;
    assign accept = bus.in_valid && ready && !bus.flush;

    // Entry register: flush beats accept beats consume; instr/pc persist on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= bus.in_instr;
            pc_q    <= bus.in_pc;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    id_imm_decode u_dec (
        .instr    (instr_q),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .rd       (dec_rd),
        .imm16    (dec_imm16),
        .se       (dec_se),
        .is_itype (dec_is_itype)
    );

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = pc_q;
    assign bus.rs        = dec_rs;
    assign bus.rt        = dec_rt;
    assign bus.rd        = dec_rd;
    assign bus.imm16     = dec_imm16;
    assign bus.se        = dec_se;
    assign bus.is_itype  = dec_is_itype;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: queue-based reference checked every cycle,
// plus directed literal expectations.
module tb_if_id_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mq[$];      // occupied slot holds {pc, instr}
    logic [31:0] m_instr;    // last loaded word, survives consume
    logic [31:0] m_pc;

    function automatic logic in_list(input logic [5:0] op, input int sel);
        int unsigned se_ops [8] = '{8, 9, 10, 11, 4, 5, 35, 43};
        int unsigned ze_ops [4] = '{12, 13, 14, 15};
        if (sel == 0) begin
            foreach (se_ops[i]) if (int'(op) == se_ops[i]) return 1'b1;
        end else begin
            foreach (ze_ops[i]) if (int'(op) == ze_ops[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic take;
        if (rst) begin
            mq.delete();
            m_instr = '0;
            m_pc    = '0;
        end else begin
            take = (mq.size() == 0) || bus.out_ready;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
                if (take && bus.in_valid) begin
                    mq.push_back({bus.in_pc, bus.in_instr});
                    m_instr = bus.in_instr;
                    m_pc    = bus.in_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] op;
        op = 6'(m_instr >> 26);
        chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("m_in_ready",  32'(bus.in_ready),  32'((mq.size() == 0) || bus.out_ready));
        chk("m_out_instr", bus.out_instr, m_instr);
        chk("m_out_pc",    bus.out_pc,    m_pc);
        chk("m_rs",        32'(bus.rs),    (m_instr >> 21) & 32'h1F);
        chk("m_rt",        32'(bus.rt),    (m_instr >> 16) & 32'h1F);
        chk("m_rd",        32'(bus.rd),    (m_instr >> 11) & 32'h1F);
        chk("m_imm16",     32'(bus.imm16), m_instr & 32'hFFFF);
        chk("m_se",        32'(bus.se),    32'(in_list(op, 0)));
        chk("m_is_itype",  32'(bus.is_itype), 32'(in_list(op, 0) || in_list(op, 1)));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_pc    = pc;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_imm16",     32'(bus.imm16),     32'd0);
        chk("rst_se",        32'(bus.se),        32'd0);
        chk("rst_is_itype",  32'(bus.is_itype),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi $8, $0, -4
        present(1'b1, 32'h2008FFFC, 32'h100);
        tick();
        present(1'b0, '0, '0);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_rs",    32'(bus.rs),        32'd0);
        chk("addi_rt",    32'(bus.rt),        32'd8);
        chk("addi_imm16", 32'(bus.imm16),     32'hFFFC);
        chk("addi_se",    32'(bus.se),        32'd1);
        chk("addi_itype", 32'(bus.is_itype),  32'd1);
        chk("addi_pc",    bus.out_pc,         32'h100);

        // ori: zero-extended immediate
        present(1'b1, 32'h3508FFFC, 32'h104);
        tick();
        present(1'b0, '0, '0);
        chk("ori_se",    32'(bus.se),       32'd0);
        chk("ori_itype", 32'(bus.is_itype), 32'd1);

        // R-type add $10, $8, $9
        present(1'b1, 32'h01095020, 32'h108);
        tick();
        present(1'b0, '0, '0);
        chk("add_se",    32'(bus.se),       32'd0);
        chk("add_itype", 32'(bus.is_itype), 32'd0);
        chk("add_rd",    32'(bus.rd),       32'd10);
        chk("add_rs",    32'(bus.rs),       32'd8);
        chk("add_rt",    32'(bus.rt),       32'd9);

        // undefined opcode 0x3F
        present(1'b1, 32'hFC001234, 32'h10C);
        tick();
        present(1'b0, '0, '0);
        chk("undef_se",    32'(bus.se),       32'd0);
        chk("undef_itype", 32'(bus.is_itype), 32'd0);
        chk("undef_imm16", 32'(bus.imm16),    32'h1234);
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // stall: hold A while B waits
        bus.out_ready = 1'b0;
        present(1'b1, 32'h24010005, 32'h200);
        tick();
        present(1'b1, 32'h8C220004, 32'h204);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
            chk("stall_instr", bus.out_instr, 32'h24010005);
            chk("stall_pc",    bus.out_pc,    32'h200);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        present(1'b0, '0, '0);
        chk("release_valid", 32'(bus.out_valid), 32'd1);
        chk("release_instr", bus.out_instr, 32'h8C220004);
        chk("release_pc",    bus.out_pc,    32'h204);

        // back-to-back: one new instruction every edge
        for (int i = 0; i < 8; i++) begin
            present(1'b1, 32'h20000000 | 32'(i), 32'h300 + 32'(4 * i));
            tick();
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_pc",    bus.out_pc,         32'h300 + 32'(4 * i));
            chk("b2b_imm",   32'(bus.imm16),     32'(i));
        end
        present(1'b0, '0, '0);
        tick();
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // flush together with accept of lw
        present(1'b1, 32'h8C220004, 32'h400);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        present(1'b0, '0, '0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        present(1'b1, 32'hAC220008, 32'h404);
        tick();
        present(1'b0, '0, '0);
        chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
        chk("post_flush_pc",    bus.out_pc,         32'h404);
        chk("post_flush_se",    32'(bus.se),        32'd1);

        // flush of a stalled entry
        bus.out_ready = 1'b0;
        present(1'b1, 32'h2008FFFC, 32'h408);
        tick();
        present(1'b0, '0, '0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_held_valid", 32'(bus.out_valid), 32'd0);

        // async reset while stalled with a valid entry
        present(1'b1, 32'h2008FFFC, 32'h500);
        tick();
        present(1'b0, '0, '0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid",    32'(bus.out_valid), 32'd0);
        chk("arst_imm16",    32'(bus.imm16),     32'd0);
        chk("arst_se",       32'(bus.se),        32'd0);
        chk("arst_in_ready", 32'(bus.in_ready),  32'd1);
        chk("arst_pc",       bus.out_pc,         32'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register and immediate-field decoder for the simple CPU. Captures a fetched instruction and its PC from the fetch stage under a valid/ready handshake, holds it across downstream stalls, and presents the decoded register fields, the raw 16-bit immediate and the sign-extend select consumed directly by the 16→32 extender in the decode stage. A flush input kills the held instruction on branch redirect.

## Interface

Parameters:
- none. Widths are fixed by the ISA: 32-bit instruction, 32-bit PC.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  fetched instruction word.
- in_pc  in  32  PC of in_instr.
- flush  in  1  kill held and incoming instruction (branch redirect).
- out_valid  out  1  held instruction valid.
- out_ready  in  1  decode/execute consumes the held instruction this cycle.
- out_pc  out  32  held PC.
- out_instr  out  32  held instruction word.
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- imm16  out  16  instr[15:0], to the extender X input.
- se  out  1  sign-extend select, to the extender Se input.
- is_itype  out  1  opcode is one of the I-type opcodes listed below.

## Operation

- Storage: one entry (valid bit, instr, pc). rs/rt/rd/imm16/se/is_itype are combinational decodes of the held instr register, not of in_instr.
- in_ready = !out_valid || out_ready (single-entry pass-through; combinational path from out_ready is intended).
- Accept when in_valid && in_ready && !flush: load instr and pc, out_valid ← 1.
- Consume without accept (out_valid && out_ready, no accept): out_valid ← 0; instr/pc keep their values.
- Hold: out_valid && !out_ready → all registers unchanged; in_ready = 0.
- flush: out_valid ← 0 next edge, incoming instruction dropped even if in_valid && in_ready; in_ready is still driven by the rule above. flush takes priority over accept and consume.
- se decode, from opcode instr[31:26]:
  - se = 1 for addi 001000, addiu 001001, slti 001010, sltiu 001011, beq 000100, bne 000101, lw 100011, sw 101011.
  - se = 0 for andi 001100, ori 001101, xori 001110, lui 001111, R-type 000000 and every undefined opcode.
- is_itype = 1 for exactly the twelve opcodes listed for se (both groups); 0 otherwise.
- Decoded outputs are driven regardless of out_valid; consumers qualify with out_valid.

## Timing

- Reset (async assert): out_valid = 0, instr = 0x00000000, pc = 0x00000000. So rs = rt = rd = 0, imm16 = 0, se = 0, is_itype = 0, and in_ready = 1 while rst is high.
- Release: the first accept can happen on the first rising edge after rst deasserts.
- Latency: 1 cycle from accept edge to out_valid and decoded fields.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Simultaneous consume and accept on the same edge: the new instruction replaces the old one and out_valid stays 1.
- Simultaneous flush and accept: flush wins, so out_valid = 0 next cycle.
- Reset mid-stall: held instruction lost, out_valid = 0 immediately (asynchronous).

## Structure

- Shared package isa_pkg: 6-bit opcode localparams (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW), and field bit positions. The later control unit reuses the same package.
- One sub-module: id_imm_decode, a combinational block mapping instr[31:0] to rs, rt, rd, imm16, se and is_itype. The top holds registers and handshake only.

## Test plan

- Reset: assert rst mid-run with out_valid = 1 → out_valid = 0, imm16 = 0, se = 0, in_ready = 1 without waiting for a clock edge.
- Sign-extend decode: accept 0x2008FFFC (addi) → next cycle out_valid = 1, rs = 0, rt = 8, imm16 = 0xFFFC, se = 1, is_itype = 1. Accept 0x3508FFFC (ori) → se = 0, is_itype = 1. Accept 0x01095020 (R-type add) → se = 0, is_itype = 0, rd = 10.
- Stall: hold out_ready = 0 for 3 cycles with new in_valid data → in_ready = 0, out_instr and out_pc unchanged. On release, the next instruction loads on that edge.
- Back-to-back: 8 instructions with in_valid = out_ready = 1 → 8 consecutive out_valid cycles, order and PCs preserved.
- Flush: flush = 1 together with an accept of 0x8C220004 (lw) → out_valid = 0 next cycle. The next accepted instruction appears normally.
- Undefined opcode 0x3F → se = 0, is_itype = 0.
